// File: rtl/floo_axis_flit_demux.sv
// Receive-side AXIS unpacker: splits single-channel beats into req/rsp flit streams,
// each buffered in its own FIFO. Optional counters enabled by FLOO_AXIS_DEMUX_STATS_EN.

module floo_axis_demux_fifo #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 full_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;

  logic [PtrWidth-1:0]  r_wptr;
  logic [PtrWidth-1:0]  r_rptr;
  logic [CntWidth-1:0]  r_cnt;
  logic [DataWidth-1:0] r_mem [Depth];
  logic                 w_push;
  logic                 w_pop;

  assign full_o  = (r_cnt == CntWidth'(Depth));
  assign valid_o = (r_cnt != '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = valid_o && ready_i;
  // Stale entries stay hidden behind an empty FIFO, so the output reads zero then.
  assign data_o  = valid_o ? r_mem[r_rptr] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define
  // which entries are live, and resetting the array would only cost flops.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

module floo_axis_flit_demux #(
  parameter int unsigned ReqDataWidth = 64,
  parameter int unsigned RspDataWidth = 64,
  parameter int unsigned FifoDepth    = 4,
  parameter int unsigned TDataWidth   = 72
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    axis_tvalid_i,
  output logic                    axis_tready_o,
  input  logic [TDataWidth-1:0]   axis_tdata_i,
  input  logic                    axis_tlast_i,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic [ReqDataWidth-1:0] req_data_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [RspDataWidth-1:0] rsp_data_o,
  output logic [31:0]             req_cnt_o,
  output logic [31:0]             rsp_cnt_o,
  output logic [31:0]             stall_cnt_o
);

  localparam int unsigned HdrPos =
      (ReqDataWidth > RspDataWidth) ? ReqDataWidth : RspDataWidth;

  logic w_sel;
  logic w_req_full;
  logic w_rsp_full;
  logic w_accept;
  logic w_req_push;
  logic w_rsp_push;
  logic w_unused;

  assign w_sel         = axis_tdata_i[HdrPos];
  // Acceptance looks only at the FIFO the header selects.
  assign axis_tready_o = !rst_i && !(w_sel ? w_rsp_full : w_req_full);
  assign w_accept      = axis_tvalid_i && axis_tready_o;
  assign w_req_push    = w_accept && !w_sel;
  assign w_rsp_push    = w_accept && w_sel;
  assign w_unused      = ^{axis_tlast_i, axis_tdata_i};

  floo_axis_demux_fifo #(
    .DataWidth (ReqDataWidth),
    .Depth     (FifoDepth)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_req_push),
    .data_i  (axis_tdata_i[ReqDataWidth-1:0]),
    .full_o  (w_req_full),
    .valid_o (req_valid_o),
    .ready_i (req_ready_i),
    .data_o  (req_data_o)
  );

  floo_axis_demux_fifo #(
    .DataWidth (RspDataWidth),
    .Depth     (FifoDepth)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_rsp_push),
    .data_i  (axis_tdata_i[RspDataWidth-1:0]),
    .full_o  (w_rsp_full),
    .valid_o (rsp_valid_o),
    .ready_i (rsp_ready_i),
    .data_o  (rsp_data_o)
  );

`ifdef FLOO_AXIS_DEMUX_STATS_EN
  logic [31:0] r_req_cnt;
  logic [31:0] r_rsp_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req_cnt   <= '0;
      r_rsp_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_req_push) r_req_cnt <= r_req_cnt + 32'd1;
      if (w_rsp_push) r_rsp_cnt <= r_rsp_cnt + 32'd1;
      if (axis_tvalid_i && !axis_tready_o) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign req_cnt_o   = r_req_cnt;
  assign rsp_cnt_o   = r_rsp_cnt;
  assign stall_cnt_o = r_stall_cnt;
`else
  assign req_cnt_o   = '0;
  assign rsp_cnt_o   = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_floo_axis_flit_demux.sv
// Directed bench for floo_axis_flit_demux with per-channel scoreboard queues;
// counter expectations follow FLOO_AXIS_DEMUX_STATS_EN.

module tb_floo_axis_flit_demux;

  localparam int unsigned ReqW = 64;
  localparam int unsigned RspW = 64;
  localparam int unsigned Depth = 4;
  localparam int unsigned TdW = 72;
  localparam int unsigned Hdr = 64;
`ifdef FLOO_AXIS_DEMUX_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            axis_tvalid_i;
  logic            axis_tready_o;
  logic [TdW-1:0]  axis_tdata_i;
  logic            axis_tlast_i;
  logic            req_valid_o;
  logic            req_ready_i;
  logic [ReqW-1:0] req_data_o;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [RspW-1:0] rsp_data_o;
  logic [31:0]     req_cnt_o;
  logic [31:0]     rsp_cnt_o;
  logic [31:0]     stall_cnt_o;

  int errors = 0;
  int checks = 0;
  logic [63:0] req_q[$];
  logic [63:0] rsp_q[$];
  bit rand_rdy = 1'b0;

  floo_axis_flit_demux #(
    .ReqDataWidth (ReqW),
    .RspDataWidth (RspW),
    .FifoDepth    (Depth),
    .TDataWidth   (TdW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .axis_tvalid_i (axis_tvalid_i),
    .axis_tready_o (axis_tready_o),
    .axis_tdata_i  (axis_tdata_i),
    .axis_tlast_i  (axis_tlast_i),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_data_o    (req_data_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .req_cnt_o     (req_cnt_o),
    .rsp_cnt_o     (rsp_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [TdW-1:0] mk(input logic hdr, input logic [63:0] p);
    logic [TdW-1:0] d;
    d = '0;
    d[63:0] = p;
    d[Hdr] = hdr;
    return d;
  endfunction

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
    return StatsEn ? v : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one beat and wait (bounded) until it is accepted; returns stalled cycles.
  task automatic send(input logic hdr, input logic [63:0] p, output int waited);
    axis_tvalid_i = 1'b1;
    axis_tdata_i  = mk(hdr, p);
    waited = 0;
    @(negedge clk_i);
    while (!axis_tready_o && waited < 64) begin
      waited++;
      @(negedge clk_i);
    end
    if (waited >= 64) check("send_timeout", 64'(axis_tready_o), 64'd1);
    tick();
  endtask

  task automatic drain();
    int n;
    req_ready_i = 1'b1;
    rsp_ready_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while ((req_valid_o || rsp_valid_o) && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    check("drain_done", {62'd0, req_valid_o, rsp_valid_o}, 64'd0);
    tick();
    req_ready_i = 1'b0;
    rsp_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    axis_tvalid_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  // Scoreboard: record accepted beats, compare every output handshake in order.
  always @(negedge clk_i) begin
    if (rst_i) begin
      req_q.delete();
      rsp_q.delete();
    end else begin
      if (req_valid_o && req_ready_i) begin
        if (req_q.size() == 0) check("req_extra_flit", 64'(req_q.size()), 64'd1);
        else check("req_data", req_data_o, req_q.pop_front());
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (rsp_q.size() == 0) check("rsp_extra_flit", 64'(rsp_q.size()), 64'd1);
        else check("rsp_data", rsp_data_o, rsp_q.pop_front());
      end
      if (axis_tvalid_i && axis_tready_o) begin
        if (axis_tdata_i[Hdr]) rsp_q.push_back(axis_tdata_i[63:0]);
        else                   req_q.push_back(axis_tdata_i[63:0]);
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (rand_rdy) begin
      req_ready_i = 1'($urandom_range(0, 1));
      rsp_ready_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst_i = 1'b1;
    axis_tvalid_i = 1'b0;
    axis_tdata_i = '0;
    axis_tlast_i = 1'b1;
    req_ready_i = 1'b0;
    rsp_ready_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    check("rst_tready", 64'(axis_tready_o), 64'd0);
    check("rst_req_valid", 64'(req_valid_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_req_data", req_data_o, 64'd0);
    check("rst_rsp_data", rsp_data_o, 64'd0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_tready", 64'(axis_tready_o), 64'd1);
    check("post_rst_valids", {62'd0, req_valid_o, rsp_valid_o}, 64'd0);
    check("post_rst_cnt", {req_cnt_o, stall_cnt_o}, 64'd0);
    tick();

    // Single req beat: no fall-through, output one cycle after acceptance
    axis_tvalid_i = 1'b1;
    axis_tdata_i  = mk(1'b0, 64'hDEAD_BEEF);
    @(negedge clk_i);
    check("single_tready", 64'(axis_tready_o), 64'd1);
    check("no_fallthrough", 64'(req_valid_o), 64'd0);
    tick();
    axis_tvalid_i = 1'b0;
    check("single_req_valid", 64'(req_valid_o), 64'd1);
    check("single_req_data", req_data_o, 64'hDEAD_BEEF);
    check("single_rsp_idle", 64'(rsp_valid_o), 64'd0);
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;

    // Fill rsp FIFO with ready low, stall on the fifth beat, then drain in order
    for (int i = 1; i <= 4; i++) begin
      send(1'b1, 64'(i), w);
      check("rsp_fill_nostall", 64'(w), 64'd0);
    end
    axis_tvalid_i = 1'b1;
    axis_tdata_i  = mk(1'b1, 64'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rsp_full_tready", 64'(axis_tready_o), 64'd0);
      tick();
    end
    check("stall_cnt_3", 64'(stall_cnt_o), 64'(cnt_exp(32'd3)));
    check("rsp_head_hold", rsp_data_o, 64'd1);
    rsp_ready_i = 1'b1;
    send(1'b1, 64'd5, w);
    check("beat5_wait", 64'(w), 64'd1);
    send(1'b1, 64'd6, w);
    check("beat6_wait", 64'(w), 64'd0);
    axis_tvalid_i = 1'b0;
    drain();
    check("stall_cnt_4", 64'(stall_cnt_o), 64'(cnt_exp(32'd4)));

    // rsp FIFO full does not block a req beat
    for (int i = 0; i < 4; i++) send(1'b1, 64'h100 + 64'(i), w);
    axis_tvalid_i = 1'b0;
    axis_tdata_i  = mk(1'b1, 64'd0);
    @(negedge clk_i);
    check("rsp_full_sel_rsp", 64'(axis_tready_o), 64'd0);
    tick();
    send(1'b0, 64'h77, w);
    axis_tvalid_i = 1'b0;
    check("req_past_full_rsp_wait", 64'(w), 64'd0);
    check("req_past_full_rsp_valid", 64'(req_valid_o), 64'd1);
    check("req_past_full_rsp_data", req_data_o, 64'h77);
    drain();
    check("req_cnt_2", 64'(req_cnt_o), 64'(cnt_exp(32'd2)));
    check("rsp_cnt_10", 64'(rsp_cnt_o), 64'(cnt_exp(32'd10)));

    // Reset with 3 req flits buffered discards them
    for (int i = 0; i < 3; i++) send(1'b0, 64'hA1 + 64'(i), w);
    axis_tvalid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_tready", 64'(axis_tready_o), 64'd0);
    tick();
    rst_i = 1'b0;
    check("midrst_req_valid", 64'(req_valid_o), 64'd0);
    check("midrst_req_data", req_data_o, 64'd0);
    check("midrst_cnt", {req_cnt_o, rsp_cnt_o}, 64'd0);
    send(1'b0, 64'h1, w);
    axis_tvalid_i = 1'b0;
    check("after_rst_valid", 64'(req_valid_o), 64'd1);
    check("after_rst_data", req_data_o, 64'h1);
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    check("after_rst_alone", 64'(req_valid_o), 64'd0);

    // 1000 interleaved beats with randomly toggling consumers
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(1'(i % 2), {$urandom, $urandom}, w);
    end
    axis_tvalid_i = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk_i);
    #2;
    drain();
    check("rand_req_q_empty", 64'(req_q.size()), 64'd0);
    check("rand_rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    check("rand_req_cnt", 64'(req_cnt_o), 64'(cnt_exp(32'd500)));
    check("rand_rsp_cnt", 64'(rsp_cnt_o), 64'(cnt_exp(32'd500)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
